// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the single-clock water-level FIFO.
// Module parameters default to these constants so every instance agrees unless overridden.
package sync_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_AF         = 252;
    localparam int DEF_AE         = 4;

    // One extra bit so a completely full FIFO (DEPTH words) is representable.
    typedef logic [DEF_ADDR_WIDTH:0] count_t;

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// The read register clears on reset; the array itself is never cleared.
module fifo_sdp_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // The read register only updates on an accepted read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with registered flags, water-level outputs and an optional
// output register stage (2-cycle read latency when OUTPUT_REG=1).
module sync_fifo_wl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL_NUM  = DEF_AF,
    parameter int ALMOST_EMPTY_NUM = DEF_AE,
    parameter int OUTPUT_REG       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic [ADDR_WIDTH:0]   wr_water_level,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  rd_empty,
    output logic [ADDR_WIDTH:0]   rd_water_level,
    output logic                  almost_empty
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = ALMOST_FULL_NUM[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = ALMOST_EMPTY_NUM[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Accept decisions use the registered flags, so a full FIFO drops a
    // simultaneous write and an empty FIFO ignores a simultaneous read.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    always_comb begin
        wptr_d  = wr_acc ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = rd_acc ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Flags are derived from count_d so they change on the same edge as the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= AF_C);
            aempty_q <= (count_d <= AE_C);
        end
    end

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (wr_data),
        .re_i    (rd_acc),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic                  valid_q;
            logic [DATA_WIDTH-1:0] dout_q;

            // Second stage only loads when the RAM stage captured a real read.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    dout_q  <= '0;
                end else begin
                    valid_q <= rd_acc;
                    if (valid_q) begin
                        dout_q <= ram_rdata;
                    end
                end
            end

            assign rd_data = dout_q;
        end else begin : g_noreg
            assign rd_data = ram_rdata;
        end
    endgenerate

    assign wr_full        = full_q;
    assign rd_empty       = empty_q;
    assign almost_full    = afull_q;
    assign almost_empty   = aempty_q;
    assign wr_water_level = count_q;
    assign rd_water_level = count_q;

endmodule

// File: tb/tb_sync_fifo_wl.sv
// Directed bench for sync_fifo_wl: fill/drain, boundary flags, collisions,
// mid-stream reset. Inputs change 1ns after a rising edge; outputs sampled there too.
module tb_sync_fifo_wl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       wr_full;
    logic [8:0] wr_water_level;
    logic       almost_full;
    logic [7:0] rd_data;
    logic       rd_en;
    logic       rd_empty;
    logic [8:0] rd_water_level;
    logic       almost_empty;

    int tests = 0;
    int fails = 0;

    sync_fifo_wl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (rd_empty !== 1'b1 || almost_empty !== 1'b1 || wr_full !== 1'b0 || almost_full !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: empty=%b aempty=%b full=%b afull=%b, want 1 1 0 0",
                     rd_empty, almost_empty, wr_full, almost_full);
        end
        tests++;
        if (wr_water_level !== 9'd0 || rd_water_level !== 9'd0) begin
            fails++;
            $display("FAIL reset_levels: wr=%0d rd=%0d, want 0 0", wr_water_level, rd_water_level);
        end
        tests++;
        if (rd_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_rd_data: got %h want 00", rd_data);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_fill();
        int exp;
        for (int j = 0; j < 257; j++) begin
            wr_en = 1'b1;
            wr_data = 8'(255 - j);
            tick();
            exp = (j + 1 > 256) ? 256 : j + 1;
            tests++;
            if (wr_water_level !== 9'(exp) || rd_water_level !== 9'(exp)) begin
                fails++;
                $display("FAIL fill_level[%0d]: wr=%0d rd=%0d want %0d", j, wr_water_level, rd_water_level, exp);
            end
            tests++;
            if (almost_empty !== (exp <= 4) || almost_full !== (exp >= 252)
                || wr_full !== (exp == 256) || rd_empty !== 1'b0) begin
                fails++;
                $display("FAIL fill_flags[%0d]: aempty=%b afull=%b full=%b empty=%b at level %0d",
                         j, almost_empty, almost_full, wr_full, rd_empty, exp);
            end
        end
        wr_en = 1'b0;
        $display("[TB] test_fill done: level %0d", wr_water_level);
    endtask

    task automatic test_drain();
        int exp;
        for (int i = 0; i < 257; i++) begin
            rd_en = 1'b1;
            tick();
            if (i >= 1) begin
                tests++;
                if (rd_data !== 8'(256 - i)) begin
                    fails++;
                    $display("FAIL drain_data[%0d]: got %h want %h", i - 1, rd_data, 8'(256 - i));
                end
            end
            exp = (i >= 255) ? 0 : 255 - i;
            tests++;
            if (rd_water_level !== 9'(exp) || rd_empty !== (exp == 0) || wr_full !== 1'b0
                || almost_empty !== (exp <= 4) || almost_full !== (exp >= 252)) begin
                fails++;
                $display("FAIL drain_state[%0d]: level=%0d empty=%b full=%b aempty=%b afull=%b want level %0d",
                         i, rd_water_level, rd_empty, wr_full, almost_empty, almost_full, exp);
            end
        end
        rd_en = 1'b0;
        tick();
        tests++;
        if (rd_data !== 8'h00 || rd_empty !== 1'b1) begin
            fails++;
            $display("FAIL drain_hold: rd_data=%h empty=%b want 00 1", rd_data, rd_empty);
        end
        $display("[TB] test_drain done");
    endtask

    task automatic test_full_collision();
        for (int j = 0; j < 256; j++) begin
            wr_en = 1'b1;
            wr_data = 8'(j);
            tick();
        end
        tests++;
        if (wr_full !== 1'b1 || wr_water_level !== 9'd256) begin
            fails++;
            $display("FAIL full_before: full=%b level=%0d want 1 256", wr_full, wr_water_level);
        end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hAA;
        tick();
        tests++;
        if (wr_water_level !== 9'd255 || wr_full !== 1'b0) begin
            fails++;
            $display("FAIL full_collision: level=%0d full=%b want 255 0", wr_water_level, wr_full);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        rd_en = 1'b0;
        tick();
        tests++;
        if (rd_data !== 8'hFF || rd_empty !== 1'b1 || rd_water_level !== 9'd0) begin
            fails++;
            $display("FAIL full_drain_last: rd_data=%h empty=%b level=%0d want ff 1 0",
                     rd_data, rd_empty, rd_water_level);
        end
        $display("[TB] test_full_collision done");
    endtask

    task automatic test_empty_collision();
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
        tick();
        tests++;
        if (wr_water_level !== 9'd1 || rd_empty !== 1'b0 || rd_data !== 8'hFF) begin
            fails++;
            $display("FAIL empty_collision: level=%0d empty=%b rd_data=%h want 1 0 ff",
                     wr_water_level, rd_empty, rd_data);
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        tests++;
        if (rd_data !== 8'hFF || rd_empty !== 1'b1) begin
            fails++;
            $display("FAIL empty_latency1: rd_data=%h empty=%b want ff 1", rd_data, rd_empty);
        end
        rd_en = 1'b0;
        tick();
        tests++;
        if (rd_data !== 8'h5A) begin
            fails++;
            $display("FAIL empty_latency2: got %h want 5a", rd_data);
        end
        $display("[TB] test_empty_collision done");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(16 + i);
            tick();
        end
        wr_en = 1'b0;
        tests++;
        if (wr_water_level !== 9'd10) begin
            fails++;
            $display("FAIL mid_level: got %0d want 10", wr_water_level);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rst_n = 1'b0;
        tick();
        tests++;
        if (wr_water_level !== 9'd0 || rd_empty !== 1'b1 || almost_empty !== 1'b1 || rd_data !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset: level=%0d empty=%b aempty=%b rd_data=%h want 0 1 1 00",
                     wr_water_level, rd_empty, almost_empty, rd_data);
        end
        rst_n = 1'b1; wr_en = 1'b1; wr_data = 8'h33;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        tests++;
        if (rd_data !== 8'h33 || rd_empty !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_data: rd_data=%h empty=%b want 33 1", rd_data, rd_empty);
        end
        $display("[TB] test_mid_reset done");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_collision();
        test_empty_collision();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
